// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - update handshake bundle for the seven-segment scan controller
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      upd_val;
    logic                      upd_rdy;
    logic [4*NUM_DIGITS-1:0]   upd_data;
    logic [NUM_DIGITS-1:0]     upd_blank;

    modport master (output upd_val, output upd_data, output upd_blank, input upd_rdy);
    modport slave  (input upd_val, input upd_data, input upd_blank, output upd_rdy);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed seven-segment scan with blanking and frame-aligned updates
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 8,
    parameter int BLANK_CYC  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    seven_seg_scan_ctrl_if.slave      upd,
    output logic [3:0]                dec_in,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done
);
    localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             idx, idx_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic                      frame_edge;
    logic                      pending;
    logic [4*NUM_DIGITS-1:0]   buf_data, shadow_data;
    logic [NUM_DIGITS-1:0]     buf_blank, shadow_blank;

    assign upd.upd_rdy = ~pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            frame_done <= frame_edge;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        frame_edge = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                cnt_nxt = '0;
                if (en) state_nxt = BLANK;
            end
            BLANK: begin
                if (!en) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SHOW: begin
                if (!en) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == DWELL_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt    = '0;
                        frame_edge = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        dec_in   = 4'h0;
        digit_en = '0;
        case (state)
            BLANK: dec_in = shadow_data[{idx, 2'b00} +: 4];
            SHOW: begin
                dec_in   = shadow_data[{idx, 2'b00} +: 4];
                digit_en = (NUM_DIGITS'(1) << idx) & ~shadow_blank;
            end
            default: ;
        endcase
    end

    // Shadow only changes at frame boundaries (or while idle) so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 1'b0;
            buf_data     <= '0;
            buf_blank    <= '0;
            shadow_data  <= '0;
            shadow_blank <= '1;
        end else if (upd.upd_val && !pending) begin
            buf_data  <= upd.upd_data;
            buf_blank <= upd.upd_blank;
            pending   <= 1'b1;
        end else if (pending && (state == IDLE || frame_edge)) begin
            shadow_data  <= buf_data;
            shadow_blank <= buf_blank;
            pending      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed table-driven bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] dec_in;
    logic [3:0] digit_en;
    logic       frame_done;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;

    typedef struct {
        int         tst;
        int         cyc;
        logic [3:0] den;
        logic [3:0] dec;
        logic       fd;
    } vec_t;
    vec_t tbl[$];

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(4)) upd_if ();

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .upd        (upd_if),
        .dec_in     (dec_in),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic add(input int t, input int c, input logic [3:0] den, input logic [3:0] dec, input logic fd);
        vec_t v;
        v.tst = t; v.cyc = c; v.den = den; v.dec = dec; v.fd = fd;
        tbl.push_back(v);
    endtask

    task automatic restart(input logic [15:0] data, input logic [3:0] blank);
        rst = 1'b1; en = 1'b0; upd_if.upd_val = 1'b0;
        tick();
        rst = 1'b0;
        upd_if.upd_val = 1'b1; upd_if.upd_data = data; upd_if.upd_blank = blank;
        tick();
        upd_if.upd_val = 1'b0;
        tick();
        en = 1'b1;
        cyc = 0;
    endtask

    task automatic run_table(input int t, input int last);
        while (cyc < last) begin
            tick();
            foreach (tbl[i]) begin
                if (tbl[i].tst == t && tbl[i].cyc == cyc) begin
                    chk($sformatf("t%0d digit_en", t), int'(digit_en), int'(tbl[i].den));
                    chk($sformatf("t%0d dec_in", t), int'(dec_in), int'(tbl[i].dec));
                    chk($sformatf("t%0d frame_done", t), int'(frame_done), int'(tbl[i].fd));
                end
            end
        end
    endtask

    initial begin
        bit ok_den, ok_dec;

        // basic scan, data 0x4321
        add(2, 1, 4'b0000, 4'h1, 0);  add(2, 2, 4'b0000, 4'h1, 0);
        add(2, 3, 4'b0001, 4'h1, 0);  add(2, 10, 4'b0001, 4'h1, 0);
        add(2, 11, 4'b0000, 4'h2, 0); add(2, 12, 4'b0000, 4'h2, 0);
        add(2, 13, 4'b0010, 4'h2, 0); add(2, 20, 4'b0010, 4'h2, 0);
        add(2, 21, 4'b0000, 4'h3, 0); add(2, 23, 4'b0100, 4'h3, 0);
        add(2, 30, 4'b0100, 4'h3, 0); add(2, 31, 4'b0000, 4'h4, 0);
        add(2, 33, 4'b1000, 4'h4, 0); add(2, 40, 4'b1000, 4'h4, 0);
        add(2, 41, 4'b0000, 4'h1, 1); add(2, 42, 4'b0000, 4'h1, 0);
        add(2, 43, 4'b0001, 4'h1, 0);
        // blank mask 0101
        add(4, 3, 4'b0000, 4'h1, 0);  add(4, 10, 4'b0000, 4'h1, 0);
        add(4, 13, 4'b0010, 4'h2, 0); add(4, 20, 4'b0010, 4'h2, 0);
        add(4, 23, 4'b0000, 4'h3, 0); add(4, 30, 4'b0000, 4'h3, 0);
        add(4, 33, 4'b1000, 4'h4, 0); add(4, 40, 4'b1000, 4'h4, 0);
        add(4, 41, 4'b0000, 4'h1, 1);

        // 1: reset with en and upd_val asserted
        rst = 1'b1; en = 1'b1;
        upd_if.upd_val = 1'b1; upd_if.upd_data = 16'h9876; upd_if.upd_blank = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst digit_en", int'(digit_en), 0);
            chk("rst dec_in", int'(dec_in), 0);
            chk("rst frame_done", int'(frame_done), 0);
            chk("rst upd_rdy", int'(upd_if.upd_rdy), 1);
        end
        rst = 1'b0; en = 1'b0; upd_if.upd_val = 1'b0;
        tick();
        chk("post-rst upd_rdy", int'(upd_if.upd_rdy), 1);
        chk("post-rst digit_en", int'(digit_en), 0);

        // 2: basic scan
        restart(16'h4321, 4'b0000);
        run_table(2, 43);

        // 3: mid-frame update
        restart(16'h4321, 4'b0000);
        wait_to(13);
        upd_if.upd_val = 1'b1; upd_if.upd_data = 16'hABCD; upd_if.upd_blank = 4'b0000;
        tick();
        chk("t3 rdy after accept", int'(upd_if.upd_rdy), 0);
        upd_if.upd_data = 16'h1111;
        wait_to(23);
        chk("t3 digit2 dec_in", int'(dec_in), 3);
        wait_to(33);
        chk("t3 digit3 dec_in", int'(dec_in), 4);
        wait_to(41);
        chk("t3 frame_done", int'(frame_done), 1);
        chk("t3 new digit0", int'(dec_in), 4'hD);
        chk("t3 rdy at frame", int'(upd_if.upd_rdy), 1);
        tick();
        upd_if.upd_val = 1'b0;
        chk("t3 second accept", int'(upd_if.upd_rdy), 0);
        wait_to(43);
        chk("t3 frame2 digit0", int'(dec_in), 4'hD);
        chk("t3 frame2 den0", int'(digit_en), 1);
        wait_to(53);
        chk("t3 frame2 digit1", int'(dec_in), 4'hC);
        wait_to(81);
        chk("t3 frame3 frame_done", int'(frame_done), 1);
        chk("t3 frame3 digit0", int'(dec_in), 1);
        wait_to(93);
        chk("t3 frame3 digit1", int'(dec_in), 1);
        chk("t3 frame3 den1", int'(digit_en), 2);

        // 4: blank mask
        restart(16'h4321, 4'b0101);
        run_table(4, 41);

        // 5: disable mid-SHOW then re-enable
        restart(16'h4321, 4'b0000);
        wait_to(26);
        chk("t5 before drop", int'(digit_en), 4);
        en = 1'b0;
        tick();
        chk("t5 off digit_en", int'(digit_en), 0);
        chk("t5 off dec_in", int'(dec_in), 0);
        chk("t5 off frame_done", int'(frame_done), 0);
        en = 1'b1;
        tick();
        chk("t5 re blank dec_in", int'(dec_in), 1);
        chk("t5 re blank den", int'(digit_en), 0);
        chk("t5 re frame_done", int'(frame_done), 0);
        tick();
        chk("t5 re blank2 den", int'(digit_en), 0);
        tick();
        chk("t5 re show den", int'(digit_en), 1);

        // 6: reset mid-operation with pending update
        restart(16'h4321, 4'b0000);
        wait_to(15);
        upd_if.upd_val = 1'b1; upd_if.upd_data = 16'hABCD;
        tick();
        upd_if.upd_val = 1'b0;
        chk("t6 pending", int'(upd_if.upd_rdy), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 rdy after rst", int'(upd_if.upd_rdy), 1);
        chk("t6 idle den", int'(digit_en), 0);
        chk("t6 idle dec", int'(dec_in), 0);
        cyc = 0;
        ok_den = 1'b1; ok_dec = 1'b1;
        while (cyc < 40) begin
            if (cyc == 3) begin
                upd_if.upd_val = 1'b1; upd_if.upd_data = 16'h5678; upd_if.upd_blank = 4'b0000;
            end else begin
                upd_if.upd_val = 1'b0;
            end
            tick();
            if (digit_en != 4'b0000) ok_den = 1'b0;
            if (dec_in != 4'h0) ok_dec = 1'b0;
        end
        chk("t6 dark frame", int'(ok_den), 1);
        chk("t6 zero shadow", int'(ok_dec), 1);
        tick();
        chk("t6 boundary frame_done", int'(frame_done), 1);
        chk("t6 boundary dec_in", int'(dec_in), 8);
        wait_to(43);
        chk("t6 new show den", int'(digit_en), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
